// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the burst DMA master.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_FIN
    } dma_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'b0010;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;
    localparam logic [1:0] RESP_DECERR    = 2'b11;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: beats = min(remaining, MAX_BURST_LEN, beats left in the 4 KB page).
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  logic [11:0]          page_off,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [7:0]           axlen
);

    localparam int SIZE_LOG = $clog2(DATA_WIDTH / 8);
    // wide enough for a full 4 KB byte distance and for the word count
    localparam int CW = (LEN_WIDTH > 14) ? LEN_WIDTH : 14;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] bnd_w;
    logic [CW-1:0] cap_w;
    logic [CW-1:0] min_w;

    // three-way minimum; AxLEN is one less than the beat count
    always_comb begin
        rem_w = CW'(remaining);
        bnd_w = (CW'(BOUNDARY_4K) - CW'(page_off)) >> SIZE_LOG;
        cap_w = CW'(MAX_BURST_LEN);
        min_w = rem_w;
        if (bnd_w < min_w) min_w = bnd_w;
        if (cap_w < min_w) min_w = cap_w;
        axlen = 8'(min_w - CW'(1));
    end

endmodule

// File: rtl/axi_burst_dma_master.sv
// AXI4 burst master: splits one command into INCR bursts and streams
// data between the local memory ports and the AXI read/write channels.
module axi_burst_dma_master
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                    M_ACLK,
    input  logic                    M_ARESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]    CMD_WORDS,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic [DATA_WIDTH-1:0]   RD_DATA,
    output logic                    RD_VALID,
    input  logic                    RD_READY,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    WR_VALID,
    output logic                    WR_READY,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic [3:0]              M_ARCACHE,
    output logic [3:0]              M_ARID,
    output logic                    M_ARLOCK,
    output logic [2:0]              M_ARPROT,
    output logic [3:0]              M_ARQOS,
    output logic                    M_ARUSER,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [7:0]              M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic [3:0]              M_AWCACHE,
    output logic [3:0]              M_AWID,
    output logic                    M_AWLOCK,
    output logic [2:0]              M_AWPROT,
    output logic [3:0]              M_AWQOS,
    output logic                    M_AWUSER,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WLAST,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    input  logic [1:0]              M_BRESP
);

    localparam int SIZE_LOG = $clog2(DATA_WIDTH / 8);

    dma_state_t            state;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [7:0]            ax_len_q;
    logic [8:0]            beat_cnt;
    logic                  arvalid_q;
    logic                  awvalid_q;
    logic                  bready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic [8:0]            burst_beats;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LEN_WIDTH-1:0]  calc_rem;
    logic [7:0]            calc_len;
    logic                  next_write;
    logic                  burst_end;
    logic                  r_hs;
    logic                  w_hs;
    logic                  rdata_st;
    logic                  wdata_st;
    logic                  last_beat;

    // The calculator always looks one burst ahead: in IDLE it sizes the
    // command's first burst, otherwise the burst following the current one.
    always_comb begin
        burst_beats = {1'b0, ax_len_q} + 9'd1;
        if (state == ST_IDLE) begin
            calc_addr  = CMD_ADDR & ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
            calc_rem   = CMD_WORDS;
            next_write = CMD_WRITE;
        end else begin
            calc_addr  = addr_q + (ADDR_WIDTH'(burst_beats) << SIZE_LOG);
            calc_rem   = rem_q - LEN_WIDTH'(burst_beats);
            next_write = write_q;
        end
    end

    dma_burst_calc #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MAX_BURST_LEN(MAX_BURST_LEN),
        .LEN_WIDTH    (LEN_WIDTH)
    ) u_calc (
        .page_off (calc_addr[11:0]),
        .remaining(calc_rem),
        .axlen    (calc_len)
    );

    // Channel muxing: data paths are straight wires gated by the data states.
    always_comb begin
        rdata_st  = (state == ST_RDATA);
        wdata_st  = (state == ST_WDATA);
        last_beat = (beat_cnt == {1'b0, ax_len_q});
        r_hs      = rdata_st & M_RVALID & RD_READY;
        w_hs      = wdata_st & WR_VALID & M_WREADY;
        burst_end = ((state == ST_IDLE) & CMD_VALID) |
                    (r_hs & M_RLAST) |
                    ((state == ST_WRESP) & M_BVALID);
    end

    assign CMD_READY = (state == ST_IDLE);
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;

    assign RD_DATA   = M_RDATA;
    assign RD_VALID  = M_RVALID & rdata_st;
    assign M_RREADY  = RD_READY & rdata_st;

    assign M_WDATA   = WR_DATA;
    assign M_WVALID  = WR_VALID & wdata_st;
    assign WR_READY  = M_WREADY & wdata_st;
    assign M_WLAST   = wdata_st & last_beat;
    assign M_WSTRB   = '1;
    assign M_BREADY  = bready_q;

    assign M_ARVALID = arvalid_q;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = ax_len_q;
    assign M_ARSIZE  = 3'(SIZE_LOG);
    assign M_ARBURST = AXI_BURST_INCR;
    assign M_ARCACHE = AXI_CACHE_DEF;
    assign M_ARID    = '0;
    assign M_ARLOCK  = 1'b0;
    assign M_ARPROT  = '0;
    assign M_ARQOS   = '0;
    assign M_ARUSER  = 1'b0;

    assign M_AWVALID = awvalid_q;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = ax_len_q;
    assign M_AWSIZE  = 3'(SIZE_LOG);
    assign M_AWBURST = AXI_BURST_INCR;
    assign M_AWCACHE = AXI_CACHE_DEF;
    assign M_AWID    = '0;
    assign M_AWLOCK  = 1'b0;
    assign M_AWPROT  = '0;
    assign M_AWQOS   = '0;
    assign M_AWUSER  = 1'b0;

    // Control FSM; burst_end (accept or burst completion) overrides the
    // per-state next state and launches the next address phase or FIN.
    always_ff @(posedge M_ACLK) begin
        if (M_ARESET) begin
            state     <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            ax_len_q  <= '0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        write_q <= CMD_WRITE;
                        busy_q  <= 1'b1;
                        error_q <= 1'b0;
                    end
                end
                ST_RADDR: begin
                    if (M_ARREADY) begin
                        arvalid_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= ST_RDATA;
                    end
                end
                ST_WADDR: begin
                    if (M_AWREADY) begin
                        awvalid_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        // bad response, or RLAST not matching the expected count
                        if (M_RRESP != RESP_OKAY || (M_RLAST != last_beat))
                            error_q <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state    <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (M_BVALID) begin
                        bready_q <= 1'b0;
                        if (M_BRESP != RESP_OKAY) error_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (burst_end) begin
                addr_q <= calc_addr;
                rem_q  <= calc_rem;
                if (calc_rem == '0) begin
                    done_q <= 1'b1;
                    state  <= ST_FIN;
                end else begin
                    ax_len_q  <= calc_len;
                    arvalid_q <= ~next_write;
                    awvalid_q <= next_write;
                    state     <= next_write ? ST_WADDR : ST_RADDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_dma_master.sv
// Directed bench for axi_burst_dma_master with simple AXI slave models.
module tb_axi_burst_dma_master;

    logic        M_ACLK = 1'b0;
    logic        M_ARESET = 1'b1;
    logic        CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR = '0;
    logic [15:0] CMD_WORDS = '0;
    logic        BUSY, DONE, ERROR;
    logic [31:0] RD_DATA, WR_DATA;
    logic        RD_VALID, RD_READY, WR_VALID, WR_READY;
    logic        M_ARVALID, M_ARREADY, M_ARLOCK, M_ARUSER;
    logic [31:0] M_ARADDR, M_AWADDR, M_RDATA, M_WDATA;
    logic [7:0]  M_ARLEN, M_AWLEN;
    logic [2:0]  M_ARSIZE, M_ARPROT, M_AWSIZE, M_AWPROT;
    logic [1:0]  M_ARBURST, M_AWBURST, M_RRESP, M_BRESP;
    logic [3:0]  M_ARCACHE, M_ARID, M_ARQOS, M_AWCACHE, M_AWID, M_AWQOS, M_WSTRB;
    logic        M_RVALID = 1'b0, M_RREADY, M_RLAST = 1'b0;
    logic        M_AWVALID, M_AWREADY, M_AWLOCK, M_AWUSER;
    logic        M_WVALID, M_WREADY, M_WLAST;
    logic        M_BVALID = 1'b0, M_BREADY;

    int checks = 0;
    int errors = 0;

    // slave / environment state
    logic [31:0] ar_addr_log[$], aw_addr_log[$], rd_log[$], wd_log[$];
    logic [7:0]  ar_len_log[$], aw_len_log[$];
    logic        wl_log[$];
    logic [3:0]  ws_log[$];
    logic [39:0] rq[$];
    logic        r_busy = 1'b0;
    logic [31:0] r_addr = '0;
    logic [7:0]  r_len = '0;
    int          r_idx = 0;
    int          b_pending = 0, b_cnt = 0, bresp_err_idx = 0;
    int          aw_delay = 0, aw_wait = 0, wr_idx = 0, done_cnt = 0, stall_cnt = 0;
    logic        bp_mode = 1'b0, tog = 1'b0;
    logic        aw_stall = 1'b0;
    logic [31:0] aw_prev_a = '0;
    logic [7:0]  aw_prev_l = '0;

    always #5 M_ACLK = ~M_ACLK;

    assign M_ARREADY = 1'b1;
    assign M_AWREADY = M_AWVALID && (aw_wait >= aw_delay);
    assign RD_READY  = bp_mode ? tog : 1'b1;
    assign M_WREADY  = bp_mode ? ~tog : 1'b1;
    assign WR_VALID  = 1'b1;
    assign WR_DATA   = 32'hD000_0000 + 32'(wr_idx);
    assign M_RRESP   = 2'b00;

    axi_burst_dma_master dut (
        .M_ACLK(M_ACLK), .M_ARESET(M_ARESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WORDS(CMD_WORDS),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
        .M_ARCACHE(M_ARCACHE), .M_ARID(M_ARID), .M_ARLOCK(M_ARLOCK),
        .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARUSER(M_ARUSER),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR),
        .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
        .M_AWCACHE(M_AWCACHE), .M_AWID(M_AWID), .M_AWLOCK(M_AWLOCK),
        .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWUSER(M_AWUSER),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA),
        .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // toggle source for ready backpressure
    always @(posedge M_ACLK) tog <= ~tog;

    // AR/R slave: read data word = burst address + 4*beat; also the local read sink
    always @(posedge M_ACLK) begin
        if (M_ARESET) begin
            rq.delete();
            r_busy = 1'b0;
            M_RVALID <= 1'b0;
            M_RLAST  <= 1'b0;
        end else begin
            if (RD_VALID && RD_READY) rd_log.push_back(RD_DATA);
            if (M_ARVALID && M_ARREADY) begin
                rq.push_back({M_ARADDR, M_ARLEN});
                ar_addr_log.push_back(M_ARADDR);
                ar_len_log.push_back(M_ARLEN);
            end
            if (M_RVALID && M_RREADY) begin
                if (r_idx == int'(r_len)) r_busy = 1'b0;
                else r_idx++;
            end
            if (!r_busy && rq.size() > 0) begin
                {r_addr, r_len} = rq.pop_front();
                r_idx  = 0;
                r_busy = 1'b1;
            end
            M_RVALID <= r_busy;
            M_RDATA  <= r_addr + 32'(r_idx * 4);
            M_RLAST  <= r_busy && (r_idx == int'(r_len));
        end
    end

    // AW/W/B slave with programmable AWREADY delay and one injectable SLVERR
    always @(posedge M_ACLK) begin
        if (M_ARESET) begin
            M_BVALID <= 1'b0;
            M_BRESP  <= 2'b00;
            b_pending = 0;
            aw_wait  <= 0;
        end else begin
            if (M_AWVALID) aw_wait <= M_AWREADY ? 0 : aw_wait + 1;
            if (M_AWVALID && M_AWREADY) begin
                aw_addr_log.push_back(M_AWADDR);
                aw_len_log.push_back(M_AWLEN);
            end
            if (M_WVALID && M_WREADY) begin
                wd_log.push_back(M_WDATA);
                wl_log.push_back(M_WLAST);
                ws_log.push_back(M_WSTRB);
                wr_idx <= wr_idx + 1;
                if (M_WLAST) b_pending++;
            end
            if (M_BVALID && M_BREADY) begin
                M_BVALID <= 1'b0;
                b_cnt++;
            end else if (!M_BVALID && b_pending > 0) begin
                b_pending--;
                M_BVALID <= 1'b1;
                M_BRESP  <= (b_cnt + 1 == bresp_err_idx) ? 2'b10 : 2'b00;
            end
        end
    end

    // AW fields must hold while AWVALID waits for AWREADY
    always @(negedge M_ACLK) begin
        if (aw_stall) begin
            stall_cnt++;
            chk("aw_stable", {M_AWVALID, M_AWADDR, M_AWLEN}, {1'b1, aw_prev_a, aw_prev_l});
        end
        aw_stall  = M_AWVALID && !M_AWREADY;
        aw_prev_a = M_AWADDR;
        aw_prev_l = M_AWLEN;
    end

    always @(negedge M_ACLK) if (DONE === 1'b1) done_cnt++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete(); aw_addr_log.delete(); aw_len_log.delete();
        rd_log.delete(); wd_log.delete(); wl_log.delete(); ws_log.delete();
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [15:0] n);
        CMD_WRITE = w; CMD_ADDR = a; CMD_WORDS = n; CMD_VALID = 1'b1;
        @(negedge M_ACLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            @(negedge M_ACLK);
            n++;
        end
        chk(tag, DONE, 1);
        @(negedge M_ACLK);
    endtask

    task automatic chk_ar(input string tag, input int i, input logic [31:0] a, input logic [7:0] l);
        chk(tag, (i < ar_addr_log.size()) ? {24'h0, ar_addr_log[i], ar_len_log[i]} : '1, {24'h0, a, l});
    endtask

    task automatic chk_aw(input string tag, input int i, input logic [31:0] a, input logic [7:0] l);
        chk(tag, (i < aw_addr_log.size()) ? {24'h0, aw_addr_log[i], aw_len_log[i]} : '1, {24'h0, a, l});
    endtask

    // read data must be the contiguous word stream starting at base
    task automatic chk_rd(input string tag, input logic [31:0] base, input int n);
        int bad = 0;
        chk({tag, "_cnt"}, rd_log.size(), n);
        for (int k = 0; k < n && k < rd_log.size(); k++)
            if (rd_log[k] !== base + 32'(4 * k)) bad++;
        chk({tag, "_data"}, bad, 0);
    endtask

    // write beats: sequential source data, full strobes, WLAST at 16-beat/end positions
    task automatic chk_wr(input string tag, input int wb, input int n, input int l0, input int l1);
        int bad = 0;
        chk({tag, "_cnt"}, wd_log.size(), n);
        for (int k = 0; k < n && k < wd_log.size(); k++) begin
            if (wd_log[k] !== 32'hD000_0000 + 32'(wb + k)) bad++;
            if (ws_log[k] !== 4'hF) bad++;
            if (wl_log[k] !== (((k + 1) % l0 == 0) || (k == l1))) bad++;
        end
        chk({tag, "_beats"}, bad, 0);
    endtask

    initial begin
        int d0, b0, wb, nar;

        // reset state
        repeat (3) @(negedge M_ACLK);
        chk("rst_ctrl", {M_ARVALID, M_AWVALID, M_RREADY, M_WVALID, M_WLAST, M_BREADY,
                         RD_VALID, WR_READY, BUSY, DONE, ERROR}, 0);
        chk("rst_len", {M_ARLEN, M_AWLEN}, 0);
        M_ARESET = 1'b0;
        @(negedge M_ACLK);
        chk("idle_ready", CMD_READY, 1);
        chk("consts", {M_ARSIZE, M_ARBURST, M_ARCACHE, M_AWSIZE, M_AWBURST, M_AWCACHE},
                      {3'd2, 2'b01, 4'b0010, 3'd2, 2'b01, 4'b0010});

        // 1: read 108 words, six full bursts then 12 beats
        clear_logs(); d0 = done_cnt;
        send_cmd(1'b0, 32'h1234_0000, 16'd108);
        chk("t1_busy", {BUSY, CMD_READY}, 2'b10);
        wait_done("t1_done", 2000);
        chk("t1_ar_cnt", ar_addr_log.size(), 7);
        for (int i = 0; i < 6; i++) chk_ar("t1_ar", i, 32'h1234_0000 + 32'(64 * i), 8'd15);
        chk_ar("t1_ar_last", 6, 32'h1234_0180, 8'd11);
        chk_rd("t1_rd", 32'h1234_0000, 108);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_idle", {BUSY, ERROR, CMD_READY}, 3'b001);

        // 2: write 109 words, last burst 13 beats, 7 responses
        clear_logs(); b0 = b_cnt; wb = wr_idx;
        send_cmd(1'b1, 32'h5678_0000, 16'd109);
        wait_done("t2_done", 2000);
        chk("t2_aw_cnt", aw_addr_log.size(), 7);
        for (int i = 0; i < 6; i++) chk_aw("t2_aw", i, 32'h5678_0000 + 32'(64 * i), 8'd15);
        chk_aw("t2_aw_last", 6, 32'h5678_0180, 8'd12);
        chk_wr("t2_w", wb, 109, 16, 108);
        chk("t2_b_cnt", b_cnt - b0, 7);
        chk("t2_err", ERROR, 0);

        // 3: read crossing a 4 KB page
        clear_logs();
        send_cmd(1'b0, 32'h0000_0FF8, 16'd8);
        wait_done("t3_done", 500);
        chk("t3_ar_cnt", ar_addr_log.size(), 2);
        chk_ar("t3_ar0", 0, 32'h0000_0FF8, 8'd1);
        chk_ar("t3_ar1", 1, 32'h0000_1000, 8'd5);
        chk_rd("t3_rd", 32'h0000_0FF8, 8);

        // 4: backpressure on AWREADY, WREADY and RD_READY
        clear_logs(); wb = wr_idx;
        bp_mode = 1'b1; aw_delay = 5; stall_cnt = 0;
        send_cmd(1'b1, 32'h0000_0100, 16'd20);
        wait_done("t4w_done", 1000);
        chk("t4w_aw_cnt", aw_addr_log.size(), 2);
        chk_aw("t4w_aw0", 0, 32'h0000_0100, 8'd15);
        chk_aw("t4w_aw1", 1, 32'h0000_0140, 8'd3);
        chk_wr("t4w_w", wb, 20, 16, 19);
        chk("t4w_stalls", stall_cnt, 10);
        clear_logs();
        send_cmd(1'b0, 32'h0000_0200, 16'd20);
        wait_done("t4r_done", 1000);
        chk_ar("t4r_ar0", 0, 32'h0000_0200, 8'd15);
        chk_ar("t4r_ar1", 1, 32'h0000_0240, 8'd3);
        chk_rd("t4r_rd", 32'h0000_0200, 20);
        bp_mode = 1'b0; aw_delay = 0;

        // 5: SLVERR on the 2nd write response
        clear_logs(); b0 = b_cnt; bresp_err_idx = b_cnt + 2; d0 = done_cnt;
        send_cmd(1'b1, 32'h0000_1000, 16'd64);
        wait_done("t5_done", 2000);
        chk("t5_aw_cnt", aw_addr_log.size(), 4);
        chk("t5_b_cnt", b_cnt - b0, 4);
        chk("t5_err_sticky", ERROR, 1);
        chk("t5_done_cnt", done_cnt - d0, 1);
        bresp_err_idx = 0;
        send_cmd(1'b0, 32'h0000_2000, 16'd4);
        chk("t5_err_clear", ERROR, 0);
        wait_done("t5b_done", 500);
        chk("t5b_err", ERROR, 0);

        // 6: reset in the middle of a read burst, then a zero-length command
        clear_logs();
        send_cmd(1'b0, 32'h0000_3000, 16'd64);
        for (int n = 0; n < 300 && rd_log.size() < 5; n++) @(negedge M_ACLK);
        chk("t6_mid", rd_log.size() >= 5, 1);
        M_ARESET = 1'b1;
        @(negedge M_ACLK);
        chk("t6_rst", {M_ARVALID, M_AWVALID, M_RREADY, M_WVALID, M_BREADY,
                       RD_VALID, WR_READY, BUSY, DONE, ERROR}, 0);
        M_ARESET = 1'b0;
        @(negedge M_ACLK);
        chk("t6_ready", CMD_READY, 1);
        nar = ar_addr_log.size();
        send_cmd(1'b0, 32'h0000_4000, 16'd0);
        chk("t6_zero_done", {DONE, BUSY}, 2'b11);
        @(negedge M_ACLK);
        chk("t6_zero_end", {DONE, BUSY, CMD_READY}, 3'b001);
        repeat (3) @(negedge M_ACLK);
        chk("t6_no_ar", ar_addr_log.size(), nar);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
